sram_like_adapter: RTL and testbench

Adapter between a handshaked CPU memory port (req/addr_ok/data_ok) and one fixed-latency SRAM port (en/we/addr/wdata, rdata one cycle after en). One instance serves instruction fetch and one serves data access. Each instance holds up to DEPTH requests outstanding and returns one response per request, in order, through a response FIFO. The pipeline stages can then issue requests before earlier ones complete.

---
 rtl/sram_like_pkg.sv | 16 +
 rtl/sram_like_adapter_resp_fifo.sv | 52 +++++
 rtl/sram_like_adapter.sv | 82 ++++++++
 tb/tb_sram_like_adapter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared widths and response entry type for the CPU-port to SRAM adapter.
package sram_like_pkg;

   localparam int SRAM_LIKE_ADDR_W = 32;
   localparam int SRAM_LIKE_DATA_W = 32;
   localparam int SRAM_LIKE_STRB_W = SRAM_LIKE_DATA_W / 8;

   typedef struct packed {
      logic [SRAM_LIKE_DATA_W-1:0] data;
   } resp_entry_t;

   function automatic int strobe_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sram_like_adapter_resp_fifo.sv
// In-order response buffer; head data and status come straight from registers.
module resp_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         din,
   output logic [DATA_W-1:0]         dout,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sram_like_adapter.sv
// Bridges a req/addr_ok/data_ok CPU memory port onto a one-cycle-latency SRAM,
// keeping up to DEPTH requests outstanding with in-order responses.
module sram_like_adapter
   import sram_like_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = SRAM_LIKE_ADDR_W,
   parameter int DATA_W = SRAM_LIKE_DATA_W
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              req,
   input  logic                              wr,
   input  logic [strobe_width(DATA_W)-1:0]   wstrb,
   input  logic [ADDR_W-1:0]                 addr,
   input  logic [DATA_W-1:0]                 wdata,
   output logic                              addr_ok,
   output logic                              data_ok,
   output logic [DATA_W-1:0]                 rdata,
   input  logic                              resp_ready,
   output logic                              sram_en,
   output logic [strobe_width(DATA_W)-1:0]   sram_we,
   output logic [ADDR_W-1:0]                 sram_addr,
   output logic [DATA_W-1:0]                 sram_wdata,
   input  logic [DATA_W-1:0]                 sram_rdata
);

   localparam int PTR_W = $clog2(DEPTH);

   logic              inflight;
   logic              inflight_wr;
   logic              accept;
   logic              fifo_push;
   logic              fifo_empty;
   logic              fifo_full;
   logic [PTR_W:0]    fifo_count;
   logic [PTR_W+1:0]  occupancy;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] head_data;

   // Occupancy counts the in-flight access so addr_ok never overcommits the FIFO.
   assign occupancy = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight};
   assign addr_ok   = resetn && (occupancy < (PTR_W+2)'(DEPTH));
   assign accept    = req && addr_ok;

   assign sram_en    = accept;
   assign sram_we    = (accept && wr) ? wstrb : '0;
   assign sram_addr  = accept ? addr  : '0;
   assign sram_wdata = accept ? wdata : '0;

   assign fifo_push = inflight && !fifo_full;
   assign push_data = inflight_wr ? '0 : sram_rdata;
   assign data_ok   = !fifo_empty;
   assign rdata     = fifo_empty ? '0 : head_data;

   // A reset drops any access in flight, so its SRAM data is never captured.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inflight    <= 1'b0;
         inflight_wr <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) inflight_wr <= wr;
      end
   end

   resp_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (fifo_push),
      .pop    (data_ok && resp_ready),
      .din    (push_data),
      .dout   (head_data),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

endmodule

// File: tb/tb_sram_like_adapter.sv
// Directed bench for sram_like_adapter with a behavioural one-cycle SRAM.
module tb_sram_like_adapter;
   import sram_like_pkg::*;

   logic                        clk;
   logic                        resetn;
   logic                        req;
   logic                        wr;
   logic [SRAM_LIKE_STRB_W-1:0] wstrb;
   logic [31:0]                 addr;
   logic [31:0]                 wdata;
   logic                        addr_ok;
   logic                        data_ok;
   logic [31:0]                 rdata;
   logic                        resp_ready;
   logic                        sram_en;
   logic [SRAM_LIKE_STRB_W-1:0] sram_we;
   logic [31:0]                 sram_addr;
   logic [31:0]                 sram_wdata;
   logic [31:0]                 sram_rdata;

   int total_checks = 0;
   int bad_checks   = 0;

   logic [31:0] sram_mem [logic [31:0]];

   sram_like_adapter #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .wr         (wr),
      .wstrb      (wstrb),
      .addr       (addr),
      .wdata      (wdata),
      .addr_ok    (addr_ok),
      .data_ok    (data_ok),
      .rdata      (rdata),
      .resp_ready (resp_ready),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return sram_mem.exists(w) ? sram_mem[w] : 32'h0;
   endfunction

   // Behavioural SRAM: byte writes take effect at the edge, reads return next cycle.
   always @(posedge clk) begin
      if (sram_en) begin
         logic [31:0] w;
         logic [31:0] cur;
         w   = {sram_addr[31:2], 2'b00};
         cur = mem_read(w);
         sram_rdata <= cur;
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
         if (sram_we != '0) sram_mem[w] = cur;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   // One cycle: drive inputs just after the edge, let combinational outputs settle.
   task automatic applyStimulus(input logic s_req, input logic s_wr, input logic [3:0] s_strb,
                                input logic [31:0] s_addr, input logic [31:0] s_wdata,
                                input logic s_ready);
      @(posedge clk);
      #1;
      req        = s_req;
      wr         = s_wr;
      wstrb      = s_strb;
      addr       = s_addr;
      wdata      = s_wdata;
      resp_ready = s_ready;
      #1;
   endtask

   // The FIFO must never be asked to take a response while full.
   always @(negedge clk) begin
      if (resetn && dut.inflight)
         checkOutput("push_not_full", {31'h0, dut.u_fifo.full}, 32'h0);
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] bp_addr;
      int          accepts;
      resp_entry_t exp_q [$];

      resetn = 1'b0; req = 1'b1; wr = 1'b0; wstrb = '0; addr = 32'h0;
      wdata = 32'h0; resp_ready = 1'b1;
      sram_mem[32'h1C00_0000] = 32'h1234_5678;
      sram_mem[32'h1C00_0004] = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) sram_mem[32'(4*i)]          = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 4; i++) sram_mem[32'h100 + 32'(4*i)] = 32'hB000_0000 + 32'(i);
      for (int i = 0; i < 4; i++) sram_mem[32'h300 + 32'(4*i)] = 32'hD000_0000 + 32'(i);
      sram_mem[32'h200] = 32'hC0FF_EE00;

      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
      checkOutput("rst_data_ok", {31'h0, data_ok}, 32'h0);
      checkOutput("rst_sram_en", {31'h0, sram_en}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      @(posedge clk);
      #1 resetn = 1'b1; req = 1'b0;

      // Single read
      applyStimulus(1, 0, 4'h0, 32'h1C00_0000, 32'h0, 1);
      checkOutput("rd_sram_en", {31'h0, sram_en}, 32'h1);
      checkOutput("rd_sram_addr", sram_addr, 32'h1C00_0000);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("rd_t1_data_ok", {31'h0, data_ok}, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("rd_t2_data_ok", {31'h0, data_ok}, 32'h1);
      checkOutput("rd_t2_rdata", rdata, 32'h1234_5678);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("rd_t3_data_ok", {31'h0, data_ok}, 32'h0);

      // Partial write followed by a read of the same word
      applyStimulus(1, 1, 4'b0011, 32'h1C00_0004, 32'hAABB_CCDD, 1);
      checkOutput("wr_sram_we", {28'h0, sram_we}, 32'h3);
      checkOutput("wr_sram_wdata", sram_wdata, 32'hAABB_CCDD);
      applyStimulus(1, 0, 4'b1111, 32'h1C00_0004, 32'h0, 1);
      checkOutput("wr_rd_sram_we", {28'h0, sram_we}, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("wr_resp_ok", {31'h0, data_ok}, 32'h1);
      checkOutput("wr_resp_rdata", rdata, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("wr_rd_resp_ok", {31'h0, data_ok}, 32'h1);
      checkOutput("wr_rd_resp_rdata", rdata, 32'hFFFF_CCDD);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("wr_idle_data_ok", {31'h0, data_ok}, 32'h0);

      // Eight back-to-back reads, one response per cycle from T+2
      for (int c = 0; c < 10; c++) begin
         applyStimulus(c < 8, 0, 4'h0, 32'(4*c), 32'h0, 1);
         if (c < 8) checkOutput($sformatf("b2b_addr_ok_%0d", c), {31'h0, addr_ok}, 32'h1);
         if (c >= 2) begin
            checkOutput($sformatf("b2b_data_ok_%0d", c-2), {31'h0, data_ok}, 32'h1);
            checkOutput($sformatf("b2b_rdata_%0d", c-2), rdata, 32'hA000_0000 + 32'(c-2));
         end
      end
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("b2b_done_data_ok", {31'h0, data_ok}, 32'h0);

      // Backpressure: capacity fills at four, then drains in order
      bp_addr = 32'h100;
      accepts = 0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1, 0, 4'h0, bp_addr, 32'h0, 0);
         if (addr_ok) begin
            accepts++;
            exp_q.push_back('{data: 32'hB000_0000 + 32'(accepts-1)});
            bp_addr += 4;
         end
      end
      checkOutput("bp_accepts", 32'(accepts), 32'd4);
      checkOutput("bp_full_addr_ok", {31'h0, addr_ok}, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("bp_p0_addr_ok", {31'h0, addr_ok}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         resp_entry_t e;
         if (i > 0) begin
            applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
            if (i == 1) checkOutput("bp_p1_addr_ok", {31'h0, addr_ok}, 32'h1);
         end
         e = (exp_q.size() > 0) ? exp_q.pop_front() : '{data: 32'hB000_0000 + 32'(i)};
         checkOutput($sformatf("bp_data_ok_%0d", i), {31'h0, data_ok}, 32'h1);
         checkOutput($sformatf("bp_rdata_%0d", i), rdata, e.data);
      end
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("bp_drained", {31'h0, data_ok}, 32'h0);

      // Reset with three buffered responses and one read in flight
      for (int c = 0; c < 4; c++) applyStimulus(1, 0, 4'h0, 32'h300 + 32'(4*c), 32'h0, 0);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      req    = 1'b1;
      #1;
      checkOutput("mid_rst_data_ok", {31'h0, data_ok}, 32'h0);
      checkOutput("mid_rst_addr_ok", {31'h0, addr_ok}, 32'h0);
      checkOutput("mid_rst_sram_en", {31'h0, sram_en}, 32'h0);
      checkOutput("mid_rst_sram_addr", sram_addr, 32'h0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      req    = 1'b0;
      #1;
      checkOutput("post_rst_occupancy", {30'h0, dut.occupancy}, 32'h0);
      checkOutput("post_rst_addr_ok", {31'h0, addr_ok}, 32'h1);
      checkOutput("post_rst_data_ok", {31'h0, data_ok}, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h200, 32'h0, 1);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("post_rst_t1_ok", {31'h0, data_ok}, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("post_rst_t2_ok", {31'h0, data_ok}, 32'h1);
      checkOutput("post_rst_rdata", rdata, 32'hC0FF_EE00);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1);
      checkOutput("post_rst_t3_ok", {31'h0, data_ok}, 32'h0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
